// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the execute sequencer:
//   - datapath / register-file widths
//   - opcode encodings (0..7 legal, 8..63 illegal)
//   - sequencer state enum
//   - instruction field bit positions
//   - flag bit indices inside the {C,Z,N,V} flag vector
//   - immediate extension helpers
// ---------------------------------------------------------------------------
package exec_pkg;

  localparam int XLEN  = 32;
  localparam int RF_AW = 5;

  // Opcodes
  localparam logic [5:0] OP_AND  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_ANDI = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd5;
  localparam logic [5:0] OP_BEQ  = 6'd6;
  localparam logic [5:0] OP_BLT  = 6'd7;

  // Instruction field positions
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS1_MSB = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_MSB = 15;
  localparam int RS2_LSB = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  // Flag bit indices in the {C,Z,N,V} vector
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// ---------------------------------------------------------------------------
// instr_decoder
// Purely combinational opcode decode for the execute sequencer.
// Ports:
//   op_i          6-bit opcode
//   legal_o       opcode is one of the eight defined operations
//   is_imm_o      operand B comes from imm16 instead of the register file
//   imm_signed_o  imm16 is sign-extended (otherwise zero-extended)
//   is_branch_o   BEQ / BLT: resolves a branch, no write-back
//   writes_rd_o   result is written to rd
//   updates_cv_o  C and V flags are updated (arithmetic ops only)
//   alu_op_o      operation code presented to the ALU
// ---------------------------------------------------------------------------
module instr_decoder
  import exec_pkg::*;
(
  input  logic [5:0] op_i,
  output logic       legal_o,
  output logic       is_imm_o,
  output logic       imm_signed_o,
  output logic       is_branch_o,
  output logic       writes_rd_o,
  output logic       updates_cv_o,
  output logic [5:0] alu_op_o
);

  // Opcode to control-signal table; undefined opcodes leave everything low.
  always_comb begin
    legal_o      = 1'b0;
    is_imm_o     = 1'b0;
    imm_signed_o = 1'b0;
    is_branch_o  = 1'b0;
    writes_rd_o  = 1'b0;
    updates_cv_o = 1'b0;
    alu_op_o     = OP_AND;
    case (op_i)
      OP_AND: begin
        legal_o     = 1'b1;
        writes_rd_o = 1'b1;
        alu_op_o    = OP_AND;
      end
      OP_ADD: begin
        legal_o      = 1'b1;
        writes_rd_o  = 1'b1;
        updates_cv_o = 1'b1;
        alu_op_o     = OP_ADD;
      end
      OP_SUB: begin
        legal_o      = 1'b1;
        writes_rd_o  = 1'b1;
        updates_cv_o = 1'b1;
        alu_op_o     = OP_SUB;
      end
      OP_OR: begin
        legal_o     = 1'b1;
        writes_rd_o = 1'b1;
        alu_op_o    = OP_OR;
      end
      OP_ANDI: begin
        legal_o     = 1'b1;
        is_imm_o    = 1'b1;
        writes_rd_o = 1'b1;
        alu_op_o    = OP_AND;
      end
      OP_ADDI: begin
        legal_o      = 1'b1;
        is_imm_o     = 1'b1;
        imm_signed_o = 1'b1;
        writes_rd_o  = 1'b1;
        updates_cv_o = 1'b1;
        alu_op_o     = OP_ADD;
      end
      // Branches compare by subtraction; the ALU flags decide the outcome.
      OP_BEQ, OP_BLT: begin
        legal_o      = 1'b1;
        is_branch_o  = 1'b1;
        updates_cv_o = 1'b1;
        alu_op_o     = OP_SUB;
      end
      default: begin
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// ---------------------------------------------------------------------------
// exec_sequencer
// Multi-cycle execute sequencer driving an external combinational ALU and a
// register file with one-cycle read latency.
// Flow: IDLE -> READ -> EXEC -> WB -> IDLE (legal), IDLE -> ERR -> IDLE
// (illegal opcode).
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   instr_valid/instr_ready        instruction handshake (ready only in IDLE)
//   instr, pc_in                   instruction word and its word address
//   rf_raddr1/2, rf_rdata1/2       register-file read port (data next cycle)
//   rf_we, rf_waddr, rf_wdata      register-file write-back
//   alu_a, alu_b, alu_op           ALU operands/opcode (zero outside EXEC)
//   alu_result, alu_carry/zero/negative/overflow   ALU return path
//   flags                          registered {C,Z,N,V}
//   done, illegal                  retire pulse, undefined-opcode qualifier
//   branch_taken, branch_target    branch outcome, valid while done=1
// ---------------------------------------------------------------------------
module exec_sequencer
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [XLEN-1:0]   instr,
  input  logic [XLEN-1:0]   pc_in,
  output logic [RF_AW-1:0]  rf_raddr1,
  output logic [RF_AW-1:0]  rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  output logic              rf_we,
  output logic [RF_AW-1:0]  rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [5:0]        alu_op,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  output logic [3:0]        flags,
  output logic              done,
  output logic              illegal,
  output logic              branch_taken,
  output logic [XLEN-1:0]   branch_target
);

  state_e             state_q, state_d;

  // Latched instruction fields (only what later states need)
  logic [5:0]         op_q;
  logic [RF_AW-1:0]   rd_q;
  logic [15:0]        imm_q;
  logic [XLEN-1:0]    pc_q;

  // Registered outputs
  logic               instr_ready_q;
  logic [RF_AW-1:0]   rf_raddr1_q, rf_raddr2_q;
  logic               rf_we_q;
  logic [RF_AW-1:0]   rf_waddr_q;
  logic [XLEN-1:0]    rf_wdata_q;
  logic [3:0]         flags_q;
  logic               done_q, illegal_q, branch_taken_q;
  logic [XLEN-1:0]    branch_target_q;

  // Combinational helpers
  logic               accept_s;
  logic [5:0]         dec_op_s;
  logic               dec_legal_s, dec_is_imm_s, dec_imm_signed_s;
  logic               dec_is_branch_s, dec_writes_rd_s, dec_updates_cv_s;
  logic [5:0]         dec_alu_op_s;
  logic [XLEN-1:0]    alu_a_s, alu_b_s;
  logic [5:0]         alu_op_s;

  assign accept_s = instr_valid && instr_ready_q && (state_q == ST_IDLE);

  // In IDLE the live instruction is decoded so legality is known at accept;
  // afterwards the latched opcode keeps the decode stable.
  assign dec_op_s = (state_q == ST_IDLE) ? instr[OP_MSB:OP_LSB] : op_q;

  instr_decoder u_dec (
    .op_i         (dec_op_s),
    .legal_o      (dec_legal_s),
    .is_imm_o     (dec_is_imm_s),
    .imm_signed_o (dec_imm_signed_s),
    .is_branch_o  (dec_is_branch_s),
    .writes_rd_o  (dec_writes_rd_s),
    .updates_cv_o (dec_updates_cv_s),
    .alu_op_o     (dec_alu_op_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (dec_legal_s) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU drive: read data arrives during EXEC, so operands are passed
  // straight through in that state and forced to zero elsewhere.
  always_comb begin
    alu_a_s  = {XLEN{1'b0}};
    alu_b_s  = {XLEN{1'b0}};
    alu_op_s = 6'd0;
    if (state_q == ST_EXEC) begin
      alu_a_s  = rf_rdata1;
      alu_op_s = dec_alu_op_s;
      if (dec_is_imm_s) begin
        if (dec_imm_signed_s) begin
          alu_b_s = sext16(imm_q);
        end else begin
          alu_b_s = zext16(imm_q);
        end
      end else begin
        alu_b_s = rf_rdata2;
      end
    end else begin
      alu_a_s  = {XLEN{1'b0}};
      alu_b_s  = {XLEN{1'b0}};
      alu_op_s = 6'd0;
    end
  end

  // Instruction latch and registered outputs (pulses default low each cycle)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q            <= 6'd0;
      rd_q            <= {RF_AW{1'b0}};
      imm_q           <= 16'h0000;
      pc_q            <= {XLEN{1'b0}};
      instr_ready_q   <= 1'b0;
      rf_raddr1_q     <= {RF_AW{1'b0}};
      rf_raddr2_q     <= {RF_AW{1'b0}};
      rf_we_q         <= 1'b0;
      rf_waddr_q      <= {RF_AW{1'b0}};
      rf_wdata_q      <= {XLEN{1'b0}};
      flags_q         <= 4'b0000;
      done_q          <= 1'b0;
      illegal_q       <= 1'b0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= {XLEN{1'b0}};
    end else begin
      rf_we_q         <= 1'b0;
      rf_waddr_q      <= {RF_AW{1'b0}};
      rf_wdata_q      <= {XLEN{1'b0}};
      done_q          <= 1'b0;
      illegal_q       <= 1'b0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= {XLEN{1'b0}};
      instr_ready_q   <= (state_d == ST_IDLE);

      if (accept_s) begin
        op_q  <= instr[OP_MSB:OP_LSB];
        rd_q  <= instr[RD_MSB:RD_LSB];
        imm_q <= instr[IMM_MSB:IMM_LSB];
        pc_q  <= pc_in;
        if (dec_legal_s) begin
          rf_raddr1_q <= instr[RS1_MSB:RS1_LSB];
          // Branches compare rs1 against the register named in the rd field.
          rf_raddr2_q <= dec_is_branch_s ? instr[RD_MSB:RD_LSB]
                                         : instr[RS2_MSB:RS2_LSB];
        end else begin
          done_q    <= 1'b1;
          illegal_q <= 1'b1;
        end
      end else if (state_q == ST_READ) begin
        rf_raddr1_q <= {RF_AW{1'b0}};
        rf_raddr2_q <= {RF_AW{1'b0}};
      end

      if (state_q == ST_EXEC) begin
        done_q <= 1'b1;
        flags_q[FLAG_Z] <= alu_zero;
        flags_q[FLAG_N] <= alu_negative;
        if (dec_updates_cv_s) begin
          flags_q[FLAG_C] <= alu_carry;
          flags_q[FLAG_V] <= alu_overflow;
        end
        if (dec_writes_rd_s && (rd_q != {RF_AW{1'b0}})) begin
          rf_we_q    <= 1'b1;
          rf_waddr_q <= rd_q;
          rf_wdata_q <= alu_result;
        end
        if (dec_is_branch_s) begin
          branch_taken_q  <= (op_q == OP_BEQ) ? alu_zero
                                              : (alu_negative ^ alu_overflow);
          branch_target_q <= pc_q + 32'd1 + sext16(imm_q);
        end
      end
    end
  end

  assign instr_ready   = instr_ready_q;
  assign rf_raddr1     = rf_raddr1_q;
  assign rf_raddr2     = rf_raddr2_q;
  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign alu_a         = alu_a_s;
  assign alu_b         = alu_b_s;
  assign alu_op        = alu_op_s;
  assign flags         = flags_q;
  assign done          = done_q;
  assign illegal       = illegal_q;
  assign branch_taken  = branch_taken_q;
  assign branch_target = branch_target_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exec_sequencer
// Directed bench for exec_sequencer with a behavioural register file
// (one-cycle read latency) and a behavioural ALU. ALU carry convention:
// ADD carry-out, SUB carry = borrow (a < b unsigned).
// ---------------------------------------------------------------------------
module tb_exec_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] alu_a, alu_b;
  logic [5:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_carry, alu_zero, alu_negative, alu_overflow;
  logic [3:0]  flags;
  logic        done, illegal, branch_taken;
  logic [31:0] branch_target;

  exec_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc_in(pc_in),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .flags(flags), .done(done), .illegal(illegal),
    .branch_taken(branch_taken), .branch_target(branch_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: read data registered one cycle after the address.
  logic [31:0] regs [32];
  int          we_total;

  always @(posedge clk) begin
    rf_rdata1 <= regs[rf_raddr1];
    rf_rdata2 <= regs[rf_raddr2];
    if (rf_we) we_total <= we_total + 1;
  end

  // Behavioural ALU
  logic [32:0] sum_s;
  always_comb begin
    sum_s        = 33'd0;
    alu_result   = 32'd0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      6'd0: alu_result = alu_a & alu_b;
      6'd1: begin
        sum_s        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = sum_s[31:0];
        alu_carry    = sum_s[32];
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      6'd2: begin
        alu_result   = alu_a - alu_b;
        alu_carry    = (alu_a < alu_b);
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      6'd3: alu_result = alu_a | alu_b;
      default: alu_result = 32'd0;
    endcase
    alu_zero     = (alu_result == 32'd0);
    alu_negative = alu_result[31];
  end

  int n_checks;
  int n_errors;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  // Results of the last run_instr call
  int          r_lat;
  int          r_we;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;
  logic        r_taken;
  logic [31:0] r_target;
  logic        r_ill;
  logic [31:0] r_a, r_b;
  logic [5:0]  r_op;

  // Issue one instruction at a negedge, observe up to 8 cycles until done,
  // then one more cycle to confirm the pulses dropped.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] pc);
    bit got_done;
    check_val("ready_before_issue", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr       = ins;
    pc_in       = pc;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 32'd0;
    pc_in       = 32'd0;
    got_done = 1'b0;
    r_lat = 0; r_we = 0; r_waddr = 5'd0; r_wdata = 32'd0;
    r_taken = 1'b0; r_target = 32'd0; r_ill = 1'b0;
    r_a = 32'd0; r_b = 32'd0; r_op = 6'd0;
    for (int c = 1; c <= 8 && !got_done; c++) begin
      @(negedge clk);
      if (c == 2) begin
        r_a = alu_a; r_b = alu_b; r_op = alu_op;
      end
      if (rf_we) begin
        r_we++; r_waddr = rf_waddr; r_wdata = rf_wdata;
      end
      if (done) begin
        got_done = 1'b1;
        r_lat    = c;
        r_taken  = branch_taken;
        r_target = branch_target;
        r_ill    = illegal;
      end
    end
    @(negedge clk);
    if (rf_we) r_we++;
    check_val("done_single_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; we_total = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0; pc_in = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", {31'd0, instr_ready}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_we", {31'd0, rf_we}, 32'd0);
    check_val("rst_flags", {28'd0, flags}, 32'd0);
    check_val("rst_aluop", {26'd0, alu_op}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("ready_after_rst", {31'd0, instr_ready}, 32'd1);

    // ADD r3,r1,r2
    regs[1] = 32'd5; regs[2] = 32'd7;
    run_instr(mk_r(6'd1, 5'd3, 5'd1, 5'd2), 32'h0);
    check_val("add_lat", r_lat, 32'd3);
    check_val("add_we", r_we, 32'd1);
    check_val("add_waddr", {27'd0, r_waddr}, 32'd3);
    check_val("add_wdata", r_wdata, 32'd12);
    check_val("add_alu_a", r_a, 32'd5);
    check_val("add_alu_b", r_b, 32'd7);
    check_val("add_alu_op", {26'd0, r_op}, 32'd1);
    check_val("add_flags", {28'd0, flags}, 32'h0);
    check_val("add_total_we", we_total, 32'd1);

    // ADDI r4,r1,1 overflow
    regs[1] = 32'h7FFF_FFFF;
    run_instr(mk_i(6'd5, 5'd4, 5'd1, 16'h0001), 32'h4);
    check_val("addi_lat", r_lat, 32'd3);
    check_val("addi_wdata", r_wdata, 32'h8000_0000);
    check_val("addi_alu_b", r_b, 32'd1);
    check_val("addi_flags", {28'd0, flags}, 32'h3);

    // ANDI zero-extends; C,V held from ADDI (C=0,V=1)
    regs[1] = 32'hFFFF_FFFF;
    run_instr(mk_i(6'd4, 5'd6, 5'd1, 16'h8001), 32'h5);
    check_val("andi_alu_b", r_b, 32'h0000_8001);
    check_val("andi_wdata", r_wdata, 32'h0000_8001);
    check_val("andi_flags", {28'd0, flags}, 32'h1);

    // BEQ taken, backwards target
    regs[1] = 32'd3; regs[2] = 32'd3;
    run_instr(mk_i(6'd6, 5'd2, 5'd1, 16'hFFFE), 32'h10);
    check_val("beq_lat", r_lat, 32'd3);
    check_val("beq_taken", {31'd0, r_taken}, 32'd1);
    check_val("beq_target", r_target, 32'h0000_000F);
    check_val("beq_we", r_we, 32'd0);
    check_val("beq_alu_b", r_b, 32'd3);
    check_val("beq_alu_op", {26'd0, r_op}, 32'd2);
    check_val("beq_flags", {28'd0, flags}, 32'h4);

    // BLT taken (2<5), then AND keeps C,V from BLT
    regs[1] = 32'd2; regs[2] = 32'd5;
    run_instr(mk_i(6'd7, 5'd2, 5'd1, 16'h0004), 32'h0);
    check_val("blt_taken", {31'd0, r_taken}, 32'd1);
    check_val("blt_target", r_target, 32'd5);
    check_val("blt_we", r_we, 32'd0);
    check_val("blt_flags", {28'd0, flags}, 32'hA);
    run_instr(mk_r(6'd0, 5'd5, 5'd1, 5'd2), 32'h1);
    check_val("and_waddr", {27'd0, r_waddr}, 32'd5);
    check_val("and_wdata", r_wdata, 32'd0);
    check_val("and_flags", {28'd0, flags}, 32'hC);

    // Illegal opcodes
    run_instr(mk_r(6'h3F, 5'd3, 5'd1, 5'd2), 32'h2);
    check_val("ill3f_lat", r_lat, 32'd1);
    check_val("ill3f_flag", {31'd0, r_ill}, 32'd1);
    check_val("ill3f_we", r_we, 32'd0);
    check_val("ill3f_flags", {28'd0, flags}, 32'hC);
    run_instr(mk_r(6'd8, 5'd3, 5'd1, 5'd2), 32'h3);
    check_val("ill8_lat", r_lat, 32'd1);
    check_val("ill8_flag", {31'd0, r_ill}, 32'd1);

    // ADD r0: done but no write
    regs[1] = 32'h8000_0000; regs[2] = 32'h8000_0000;
    run_instr(mk_r(6'd1, 5'd0, 5'd1, 5'd2), 32'h4);
    check_val("addr0_lat", r_lat, 32'd3);
    check_val("addr0_ill", {31'd0, r_ill}, 32'd0);
    check_val("addr0_we", r_we, 32'd0);
    check_val("addr0_flags", {28'd0, flags}, 32'hD);

    // Reset asserted during EXEC of ADD r7
    regs[1] = 32'd1; regs[2] = 32'd1;
    check_val("pre_rst_total_we", we_total, 32'd4);
    instr_valid = 1'b1; instr = mk_r(6'd1, 5'd7, 5'd1, 5'd2); pc_in = 32'h20;
    @(posedge clk);
    #1;
    instr_valid = 1'b0; instr = 32'd0; pc_in = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check_val("mid_exec_aluop", {26'd0, alu_op}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("abort_we", {31'd0, rf_we}, 32'd0);
    check_val("abort_done", {31'd0, done}, 32'd0);
    check_val("abort_flags", {28'd0, flags}, 32'h0);
    check_val("abort_ready", {31'd0, instr_ready}, 32'd0);
    check_val("abort_alu_a", alu_a, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("abort_ready_after", {31'd0, instr_ready}, 32'd1);
    check_val("abort_no_we", we_total, 32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
